// File: rtl/pipe_pkg.sv
// Shared types and constants for the parametrised pipeline stage register.
// Holds the skid FSM encoding, the RISC-V NOP and the default counter width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_t;

  localparam logic [31:0] RISCV_NOP = 32'h00000013;
  localparam int          CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the stall and bubble statistics.
// Holds at all-ones instead of wrapping.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && !(&r_count)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with flush, optional 2-entry skid buffer
// and saturating stall/bubble counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter bit                SKID      = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic w_stall;
  logic w_bubble;

  if (SKID) begin : g_skid
    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_skid;
    logic              r_rdy;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign w_in_xfer  = in_valid && r_rdy;
    assign w_out_xfer = (r_state != EMPTY) && out_ready;

    always_comb begin
      w_next = r_state;
      unique case (r_state)
        EMPTY: begin
          if (w_in_xfer) w_next = ONE;
        end
        ONE: begin
          if (w_in_xfer && !w_out_xfer) begin
            w_next = TWO;
          end else if (!w_in_xfer && w_out_xfer) begin
            w_next = EMPTY;
          end
        end
        TWO: begin
          if (w_out_xfer) w_next = ONE;
        end
        default: w_next = EMPTY;
      endcase
      if (flush) w_next = EMPTY;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= EMPTY;
        r_rdy   <= 1'b1;
        r_data  <= RESET_VAL;
        r_skid  <= RESET_VAL;
      end else begin
        r_state <= w_next;
        // in_ready is the registered image of the next state
        r_rdy   <= (w_next != TWO);
        if (flush) begin
          r_data <= RESET_VAL;
        end else if (r_state == TWO && w_out_xfer) begin
          r_data <= r_skid;
        end else if (w_in_xfer &&
                     (r_state == EMPTY || w_out_xfer)) begin
          r_data <= in_data;
        end
        if (!flush && w_in_xfer &&
            r_state == ONE && !w_out_xfer) begin
          r_skid <= in_data;
        end
      end
    end

    assign in_ready  = r_rdy;
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_data;
  end else begin : g_flop
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign in_ready   = out_ready || !r_valid;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_valid && out_ready;

    always_ff @(posedge clk) begin
      if (reset || flush) begin
        r_valid <= 1'b0;
        r_data  <= RESET_VAL;
      end else if (w_in_xfer) begin
        r_valid <= 1'b1;
        r_data  <= in_data;
      end else if (w_out_xfer) begin
        r_valid <= 1'b0;
      end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
  end

  assign w_stall  = out_valid && !out_ready;
  assign w_bubble = !out_valid && out_ready;

  sat_counter #(.W(CNT_W)) u_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble (
    .clk   (clk),
    .reset (reset),
    .inc   (w_bubble),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboarded bench for pipe_stage_reg in both modes.
// Index 0 is the plain register (CNT_W=16), index 1 the skid (CNT_W=4).
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush     [2];
  logic        in_valid  [2];
  logic        out_ready [2];
  logic [31:0] in_data   [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [31:0] out_data  [2];
  logic [15:0] stall0, bubble0;
  logic [3:0]  stall1, bubble1;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        pst  [2];
  logic [31:0] pdat [2];

  pipe_stage_reg #(
    .DATA_W(32), .SKID(1'b0),
    .RESET_VAL(RISCV_NOP), .CNT_W(16)
  ) u_flop (
    .clk(clk), .reset(reset), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]),
    .stall_cnt(stall0), .bubble_cnt(bubble0)
  );

  pipe_stage_reg #(
    .DATA_W(32), .SKID(1'b1),
    .RESET_VAL(RISCV_NOP), .CNT_W(4)
  ) u_skid (
    .clk(clk), .reset(reset), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]),
    .stall_cnt(stall1), .bubble_cnt(bubble1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic string t(input string s, input int m);
    return $sformatf("%s[%0d]", s, m);
  endfunction

  function automatic logic [15:0] stall_of(input int m);
    return (m == 1) ? {12'h0, stall1} : stall0;
  endfunction

  function automatic logic [15:0] bubble_of(input int m);
    return (m == 1) ? {12'h0, bubble1} : bubble0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int m);
    flush[m] = 1'b0;
    in_valid[m] = 1'b0;
    out_ready[m] = 1'b0;
    in_data[m] = 32'h0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle(0);
    idle(1);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic sb_step(input int m);
    logic [31:0] e;
    if (in_valid[m] && in_ready[m]) begin
      if (m == 1) q1.push_back(in_data[m]);
      else q0.push_back(in_data[m]);
    end
    if (out_valid[m] && out_ready[m]) begin
      if ((m == 1 ? q1.size() : q0.size()) == 0) begin
        chk(t("rnd_extra", m), out_valid[m], 0);
      end else begin
        e = (m == 1) ? q1.pop_front() : q0.pop_front();
        chk(t("rnd_data", m), out_data[m], e);
      end
    end
    pst[m] = out_valid[m] && !out_ready[m];
    pdat[m] = out_data[m];
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      flush[m] = 1'b0;
      in_valid[m] = 1'b1;
      in_data[m] = 32'hDEADBEEF;
      out_ready[m] = 1'b1;
    end
    reset = 1'b1;
    repeat (3) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        chk(t("rst_valid", m), out_valid[m], 0);
        chk(t("rst_data", m), out_data[m], 32'h13);
        chk(t("rst_stall", m), stall_of(m), 0);
        chk(t("rst_bubble", m), bubble_of(m), 0);
        chk(t("rst_ready", m), in_ready[m], 1);
      end
    end

    for (int m = 0; m < 2; m++) begin
      do_reset();
      out_ready[m] = 1'b1;
      for (int k = 1; k <= 3; k++) begin
        in_valid[m] = 1'b1;
        in_data[m] = k;
        tick();
        chk(t("str_valid", m), out_valid[m], 1);
        chk(t("str_data", m), out_data[m], k);
        chk(t("str_ready", m), in_ready[m], 1);
      end
      in_valid[m] = 1'b0;
      tick();
      chk(t("str_end", m), out_valid[m], 0);
    end

    do_reset();
    in_valid[1] = 1'b1;
    in_data[1] = 32'hA;
    tick();
    chk("fill_a_data", out_data[1], 32'hA);
    chk("fill_a_rdy", in_ready[1], 1);
    in_data[1] = 32'hB;
    tick();
    chk("fill_b_rdy", in_ready[1], 0);
    chk("fill_b_data", out_data[1], 32'hA);
    in_valid[1] = 1'b0;
    tick();
    chk("fill_hold", out_data[1], 32'hA);
    chk("fill_stall", stall_of(1), 2);
    out_ready[1] = 1'b1;
    tick();
    chk("drain_b_data", out_data[1], 32'hB);
    chk("drain_b_valid", out_valid[1], 1);
    chk("drain_rdy", in_ready[1], 1);
    tick();
    chk("drain_empty", out_valid[1], 0);
    chk("drain_stall", stall_of(1), 2);

    do_reset();
    in_valid[0] = 1'b1;
    in_data[0] = 32'hA;
    tick();
    in_data[0] = 32'hB;
    #1;
    chk("stall0_rdy", in_ready[0], 0);
    tick();
    chk("stall0_hold", out_data[0], 32'hA);
    chk("stall0_cnt", stall_of(0), 1);
    out_ready[0] = 1'b1;
    tick();
    chk("stall0_b", out_data[0], 32'hB);
    in_valid[0] = 1'b0;
    tick();
    chk("stall0_end", out_valid[0], 0);

    for (int m = 0; m < 2; m++) begin
      do_reset();
      in_valid[m] = 1'b1;
      in_data[m] = 32'h55;
      tick();
      chk(t("fl_pre", m), out_data[m], 32'h55);
      in_data[m] = 32'h66;
      flush[m] = 1'b1;
      tick();
      chk(t("fl_valid", m), out_valid[m], 0);
      chk(t("fl_data", m), out_data[m], 32'h13);
      chk(t("fl_stall", m), stall_of(m), 1);
      chk(t("fl_rdy", m), in_ready[m], 1);
      flush[m] = 1'b0;
      in_valid[m] = 1'b0;
      out_ready[m] = 1'b1;
      tick();
      tick();
      chk(t("fl_after_v", m), out_valid[m], 0);
      chk(t("fl_after_d", m), out_data[m], 32'h13);
    end

    do_reset();
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    repeat (15) tick();
    chk("sat_15", bubble_of(1), 15);
    chk("cnt_15", bubble_of(0), 15);
    repeat (5) tick();
    chk("sat_hold", bubble_of(1), 15);
    chk("cnt_20", bubble_of(0), 20);

    do_reset();
    pst[0] = 1'b0;
    pst[1] = 1'b0;
    repeat (1000) begin
      for (int m = 0; m < 2; m++) begin
        if (pst[m]) begin
          chk(t("hold_v", m), out_valid[m], 1);
          chk(t("hold_d", m), out_data[m], pdat[m]);
        end
        in_valid[m] = 1'($urandom_range(0, 1));
        in_data[m] = $urandom;
        out_ready[m] = 1'($urandom_range(0, 1));
      end
      #1;
      sb_step(0);
      sb_step(1);
      tick();
    end
    for (int m = 0; m < 2; m++) begin
      in_valid[m] = 1'b0;
      out_ready[m] = 1'b1;
    end
    repeat (4) begin
      #1;
      sb_step(0);
      sb_step(1);
      tick();
    end
    chk("rnd_left0", q0.size(), 0);
    chk("rnd_left1", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
